// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state encoding and constants for the 4:1 mux scan controller
package mux_scan_pkg;

    // Scan sequencer states; encoding is fixed so other blocks can decode it
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        FINISH  = 2'd3
    } scan_state_e;

    localparam int NUM_CH        = 4;
    localparam int DWELL_DEFAULT = 2;

    // Dwell counter is wide enough for the largest legal DWELL (15)
    localparam int DWELL_W = 4;

    // Highest channel index; reaching it in CAPTURE ends the scan
    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

endpackage

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - steps a 4:1 mux through all channels, settles, captures Y and flags Y==NY
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       Y,
    input  logic       NY,
    output logic       A0,
    output logic       A1,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample,
    output logic       err
);

    // Dwell count reached on the last settle cycle of a channel
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    scan_state_e        state_q;
    logic [1:0]         ch_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [1:0]         sel_q;
    logic               busy_q;
    logic               done_q;
    logic [3:0]         sample_q;
    logic               err_q;

    // Sequencer: state, counters, mux select and status flags all update together so
    // every output is a flop and Y/NY only ever reach sample/err through a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= 2'd0;
            dwell_q  <= '0;
            sel_q    <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= 4'b0000;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    sel_q  <= 2'b00;
                    busy_q <= 1'b0;
                    if (start) begin
                        state_q  <= SETTLE;
                        ch_q     <= 2'd0;
                        dwell_q  <= '0;
                        sample_q <= 4'b0000;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                SETTLE: begin
                    dwell_q <= dwell_q + 1'b1;
                    if (dwell_q == DWELL_LAST) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    sample_q[ch_q] <= Y;
                    if (Y == NY) begin
                        err_q <= 1'b1;
                    end
                    if (ch_q == LAST_CH) begin
                        // Select parks on the last channel through FINISH
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= SETTLE;
                        ch_q    <= ch_q + 2'd1;
                        sel_q   <= ch_q + 2'd1;
                        dwell_q <= '0;
                    end
                end
                FINISH: begin
                    // start is deliberately not looked at here; a new scan needs IDLE
                    state_q <= IDLE;
                    ch_q    <= 2'd0;
                    dwell_q <= '0;
                    sel_q   <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A0     = sel_q[0];
    assign A1     = sel_q[1];
    assign busy   = busy_q;
    assign done   = done_q;
    assign sample = sample_q;
    assign err    = err_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl at DWELL=2 and DWELL=1
module tb_mux_scan_ctrl;

    localparam int DW [2] = '{2, 1};

    typedef struct {
        int         done_cyc;
        logic [3:0] sample;
        logic       err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [1:0]      y, ny, a0, a1, busy, done, err;
    logic [1:0][3:0] sample;
    logic [1:0][3:0] d;
    logic [1:0][3:0] mask;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   next_acc [2];
    exp_t exp_q [2][$];

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4:1 mux per instance; mask forces NY equal to Y on chosen channels
    assign y[0]  = d[0][{a1[0], a0[0]}];
    assign ny[0] = mask[0][{a1[0], a0[0]}] ? y[0] : ~y[0];
    assign y[1]  = d[1][{a1[1], a0[1]}];
    assign ny[1] = mask[1][{a1[1], a0[1]}] ? y[1] : ~y[1];

    mux_scan_ctrl #(.DWELL(DW[0])) u_dut_dw2 (
        .clk(clk), .rst_n(rst_n), .start(start), .Y(y[0]), .NY(ny[0]),
        .A0(a0[0]), .A1(a1[0]), .busy(busy[0]), .done(done[0]),
        .sample(sample[0]), .err(err[0])
    );

    mux_scan_ctrl #(.DWELL(DW[1])) u_dut_dw1 (
        .clk(clk), .rst_n(rst_n), .start(start), .Y(y[1]), .NY(ny[1]),
        .A0(a0[1]), .A1(a1[1]), .busy(busy[1]), .done(done[1]),
        .sample(sample[1]), .err(err[1])
    );

    function automatic void check(input string nm, input int g, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s dut%0d (DWELL=%0d) cyc=%0d: got %0d expected %0d",
                      nm, g, DW[g], cyc, act, expv);
    endfunction

    // One stimulus cycle: the model decides acceptance from its own timing rule
    task automatic drive_cycle(input bit s, input bit rnd);
        exp_t e;
        start = s;
        for (int i = 0; i < 2; i++) begin
            if (s && (cyc + 1 >= next_acc[i])) begin
                if (rnd) begin
                    d[i]    = 4'($urandom_range(0, 15));
                    mask[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
                end
                e.done_cyc  = cyc + 1 + 4 * (DW[i] + 1);
                e.sample    = d[i];
                e.err       = |mask[i];
                exp_q[i].push_back(e);
                next_acc[i] = e.done_cyc + 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) drive_cycle(1'b0, 1'b0);
    endtask

    // Monitors: pop and compare on done, and check hold/clear behaviour around it
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic [1:0] a_log [$];
        logic [3:0] last_s;
        logic       last_e;
        logic       prev_busy;
        exp_t       e;
        int         mism;

        initial begin
            last_s    = 4'b0000;
            last_e    = 1'b0;
            prev_busy = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    a_log.delete();
                    last_s    = 4'b0000;
                    last_e    = 1'b0;
                    prev_busy = 1'b0;
                end else begin
                    if (busy[g] && !prev_busy) begin
                        check("start_clears_sample", g, int'(sample[g]), 0);
                        check("start_clears_err", g, int'(err[g]), 0);
                        check("first_sel", g, int'({a1[g], a0[g]}), 0);
                    end
                    if (busy[g]) a_log.push_back({a1[g], a0[g]});
                    if (done[g]) begin
                        check("done_expected", g, int'(exp_q[g].size() > 0), 1);
                        if (exp_q[g].size() > 0) begin
                            e = exp_q[g].pop_front();
                            check("done_cycle", g, cyc, e.done_cyc);
                            check("sample", g, int'(sample[g]), int'(e.sample));
                            check("err", g, int'(err[g]), int'(e.err));
                            check("sel_trace_len", g, a_log.size(), 4 * (DW[g] + 1));
                            mism = 0;
                            for (int t = 0; t < a_log.size(); t++)
                                if (int'(a_log[t]) != t / (DW[g] + 1)) mism++;
                            check("sel_trace_mismatches", g, mism, 0);
                            last_s = e.sample;
                            last_e = e.err;
                        end
                        check("finish_sel", g, int'({a1[g], a0[g]}), 3);
                        check("finish_busy", g, int'(busy[g]), 0);
                        a_log.delete();
                    end else if (!busy[g]) begin
                        check("idle_sample_hold", g, int'(sample[g]), int'(last_s));
                        check("idle_err_hold", g, int'(err[g]), int'(last_e));
                        check("idle_sel", g, int'({a1[g], a0[g]}), 0);
                    end
                    if (exp_q[g].size() > 0 && cyc > exp_q[g][0].done_cyc) begin
                        check("done_by_cycle", g, cyc, exp_q[g][0].done_cyc);
                        void'(exp_q[g].pop_front());
                    end
                    prev_busy = busy[g];
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        d        = '0;
        mask     = '0;
        next_acc = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_sel", i, int'({a1[i], a0[i]}), 0);
            check("rst_busy", i, int'(busy[i]), 0);
            check("rst_done", i, int'(done[i]), 0);
            check("rst_sample", i, int'(sample[i]), 0);
            check("rst_err", i, int'(err[i]), 0);
        end
        rst_n = 1'b1;
        next_acc = '{cyc + 1, cyc + 1};

        // Single pulse, D0..D3 = 1,0,1,1
        d[0] = 4'b1101;
        d[1] = 4'b1101;
        drive_cycle(1'b1, 1'b0);
        idle_cycles(20);

        // start held high: back-to-back scans with one IDLE cycle between
        d = '0;
        repeat (20) drive_cycle(1'b1, 1'b0);
        idle_cycles(20);

        // NY stuck equal to Y on channel 2, then a clean scan
        d[0]    = 4'b0110;
        d[1]    = 4'b1001;
        mask[0] = 4'b0100;
        mask[1] = 4'b0100;
        drive_cycle(1'b1, 1'b0);
        idle_cycles(20);
        mask = '0;
        drive_cycle(1'b1, 1'b0);
        idle_cycles(20);

        // Reset during channel-1 settle
        d[0] = 4'b1010;
        d[1] = 4'b0011;
        drive_cycle(1'b1, 1'b0);
        idle_cycles(3);
        for (int i = 0; i < 2; i++) check("pre_reset_sel", i, int'({a1[i], a0[i]}), 1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("midscan_rst_sel", i, int'({a1[i], a0[i]}), 0);
            check("midscan_rst_busy", i, int'(busy[i]), 0);
            check("midscan_rst_done", i, int'(done[i]), 0);
            check("midscan_rst_sample", i, int'(sample[i]), 0);
            check("midscan_rst_err", i, int'(err[i]), 0);
            exp_q[i].delete();
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        next_acc = '{cyc + 1, cyc + 1};
        drive_cycle(1'b1, 1'b0);
        idle_cycles(20);

        // Extra start pulses landing in CAPTURE and FINISH of the DWELL=2 scan
        for (int j = 0; j < 20; j++) drive_cycle(j == 0 || j == 3 || j == 13, 1'b0);
        idle_cycles(20);

        // Random traffic
        repeat (400) drive_cycle($urandom_range(0, 2) == 0, 1'b1);
        idle_cycles(30);

        for (int i = 0; i < 2; i++) check("queue_drained", i, exp_q[i].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 2, settle cycles per channel before capture; legal range 1..15.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port start  input  1  scan request; sampled only in IDLE.
REQ-005 Port Y  input  1  selected data from downstream 4:1 multiplexer.
REQ-006 Port NY  input  1  complement output from the same multiplexer.
REQ-007 Port A0  output  1  select bit 0 driven to the multiplexer.
REQ-008 Port A1  output  1  select bit 1 driven to the multiplexer.
REQ-009 Port busy  output  1  high from the cycle after accepted start through the last CAPTURE cycle.
REQ-010 Port done  output  1  single-cycle pulse at scan completion.
REQ-011 Port sample  output  4  captured channel values; bit n = value of Y with {A1,A0}=n.
REQ-012 Port err  output  1  sticky flag; Y==NY seen at any capture of the current scan.

Function
REQ-013 FSM states IDLE, SETTLE, CAPTURE, FINISH; state, channel counter (2 bits) and dwell counter all registered.
REQ-014 IDLE: {A1,A0}=2'b00, busy=0, done=0; start=1 -> SETTLE, channel=0, dwell counter=0, sample cleared to 4'b0000, err cleared to 0.
REQ-015 SETTLE: {A1,A0}=channel; dwell counter increments each cycle; after DWELL cycles in SETTLE -> CAPTURE.
REQ-016 CAPTURE: {A1,A0} held at channel; sample[channel]<=Y; if Y==NY then err<=1.
REQ-017 CAPTURE with channel<3 -> SETTLE, channel+1, dwell counter=0; CAPTURE with channel==3 -> FINISH.
REQ-018 FINISH: done=1 for exactly this cycle, busy=0, {A1,A0}=2'b11 held; next state IDLE unconditionally.
REQ-019 Latency: start sampled at edge k -> done high in cycle k+4*(DWELL+1)+1.
REQ-020 start while not in IDLE (including FINISH) ignored; no queuing.
REQ-021 sample and err hold their values from FINISH until the next accepted start.
REQ-022 A0, A1, busy and done are registered outputs; no combinational path from Y or NY to any output.
REQ-023 Channel counter wraps only through FINISH/IDLE; never increments past 3.

Reset
REQ-024 rst_n low forces immediately: state=IDLE, {A1,A0}=2'b00, busy=0, done=0, sample=4'b0000, err=0, both counters 0.
REQ-025 Reset mid-scan aborts without a done pulse; first start after rst_n rises starts a fresh scan from channel 0.
REQ-026 Deassertion of rst_n is synchronised to clk by the integrating level; this block applies no internal synchroniser.

Structure
REQ-027 Shared package mux_scan_pkg holds the state encoding (IDLE=2'd0, SETTLE=2'd1, CAPTURE=2'd2, FINISH=2'd3), NUM_CH=4 and the DWELL default.
REQ-028 Single flat module; no sub-module instantiated. The bench instantiates the existing 4:1 multiplexer as the Y/NY source.

Verification
REQ-029 DWELL=2, mux D0..D3=1,0,1,1, start pulse at edge 0 -> A sequence 00,00,00,01,01,01,10,10,10,11,11,11; done high in cycle 13; sample=4'b1101; err=0.
REQ-030 DWELL=1, D0..D3=0,0,0,0, start held high for 20 cycles -> done pulses in cycles 9 and 19 (restart after one IDLE cycle); sample=4'b0000 after each scan.
REQ-031 Force NY=Y during channel-2 capture only -> err=1 at done and held through IDLE; next scan with correct NY clears err at start.
REQ-032 rst_n low for 1 cycle during channel-1 SETTLE -> all outputs 0 at once; no done pulse; new start gives a complete, correct scan.
REQ-033 start pulse during CAPTURE and during FINISH -> ignored; exactly one done pulse; busy low in FINISH and IDLE.
